// File: rtl/asu_ddr5_crc_pkg.sv
// ---------------------------------------------------------------------------
// asu_ddr5_crc_pkg
// Shared definitions for the DDR5 write-path CRC-8 engine:
//   - CRC8_POLY / CRC8_SEED : x^8+x^2+x+1, zero seed, no reflection, no final XOR
//   - crc_state_t           : burst FSM states (IDLE, ACCUM)
//   - crc8_fold()           : unrolled MSB-first fold of up to 16 message bits
// ---------------------------------------------------------------------------
package asu_ddr5_crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_SEED = 8'h00;

  typedef enum logic {
    IDLE,
    ACCUM
  } crc_state_t;

  // Folds the top nbits of the 16-bit window into crc, highest index first.
  // bits[nbits-1] is the first message bit of the window. nbits is always a
  // constant at the call site, so the loop unrolls into a pure XOR network.
  function automatic logic [7:0] crc8_fold(input logic [7:0]  crc,
                                           input logic [15:0] bits,
                                           input int          nbits);
    logic [7:0] c;
    logic       fb;
    c  = crc;
    fb = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[7] ^ bits[i];
        c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/asu_ddr5_crc_lane.sv
// ---------------------------------------------------------------------------
// asu_ddr5_crc_lane
// One CRC-8 lane: accumulator register, seed mux and the per-cycle fold of
// one even beat followed by one odd beat.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   clear         : synchronous abort, returns the accumulator to the seed
//   enable        : fold this cycle's two beats into the accumulator
//   use_seed      : first cycle of a burst, fold starts from the seed
//   even_beat     : lane DQs of the first beat (bit 0 = lowest DQ)
//   odd_beat      : lane DQs of the second beat
//   crc_next      : CRC after folding this cycle's beats (combinational)
// ---------------------------------------------------------------------------
module asu_ddr5_crc_lane
  import asu_ddr5_crc_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              enable,
  input  logic              use_seed,
  input  logic [LANE_W-1:0] even_beat,
  input  logic [LANE_W-1:0] odd_beat,
  output logic [7:0]        crc_next
);

  logic [7:0]  crc_q;
  logic [7:0]  crc_in;
  logic [15:0] bits;

  // Lowest DQ of each beat is shifted first, so it lands at the top of the
  // fold window; the even beat precedes the odd beat.
  always_comb begin
    bits = '0;
    for (int k = 0; k < LANE_W; k++) begin
      bits[2*LANE_W-1-k] = even_beat[k];
      bits[LANE_W-1-k]   = odd_beat[k];
    end
  end

  // A new burst starts from the seed rather than the register, which lets a
  // burst follow the previous one with no bubble.
  always_comb begin
    crc_in   = use_seed ? CRC8_SEED : crc_q;
    crc_next = crc8_fold(crc_in, bits, 2*LANE_W);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      crc_q <= CRC8_SEED;
    end else if (clear) begin
      crc_q <= CRC8_SEED;
    end else if (enable) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/asu_ddr5_crc_generator.sv
// ---------------------------------------------------------------------------
// asu_ddr5_crc_generator
// DDR5 write CRC-8 engine. Accumulates one CRC per lane over a 16-beat burst
// (8 enabled cycles of two beats) and registers the CRC code word one cycle
// after the last data cycle.
// Parameter:
//   pDRAM_SIZE    : DQ width, 4, 8 or 16 (x16 uses two independent lanes)
// Ports:
//   clk_i         : PHY write clock, two DQ beats per cycle
//   rst_i         : asynchronous active-low reset
//   crc_enable_i  : crc_data_i carries one data cycle of the current burst
//   crc_data_i    : [P-1:0] even beat, [2P-1:P] odd beat
//   crc_clear_i   : synchronous abort of a partial burst (wins over enable)
//   crc_inject_i  : invert bit 0 of each lane CRC on the completing cycle
//                   (only with ASU_DDR5_CRC_ERR_INJ_EN defined)
//   crc_code_o    : CRC code word for the two CRC beats, 1-filled
//   crc_valid_o   : one-cycle pulse when crc_code_o updates
//   crc_busy_o    : a burst is partially accumulated
// Build option: ASU_DDR5_CRC_ERR_INJ_EN enables the error injection port.
// ---------------------------------------------------------------------------
module asu_ddr5_crc_generator
  import asu_ddr5_crc_pkg::*;
#(
  parameter int pDRAM_SIZE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    crc_enable_i,
  input  logic [2*pDRAM_SIZE-1:0] crc_data_i,
  input  logic                    crc_clear_i,
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
  input  logic                    crc_inject_i,
`endif
  output logic [2*pDRAM_SIZE-1:0] crc_code_o,
  output logic                    crc_valid_o,
  output logic                    crc_busy_o
);

  localparam int NUM_LANES = (pDRAM_SIZE == 16) ? 2 : 1;
  localparam int LANE_W    = (pDRAM_SIZE == 4) ? 4 : 8;
  localparam int CODE_W    = 2 * pDRAM_SIZE;

  generate
    if (!(pDRAM_SIZE == 4 || pDRAM_SIZE == 8 || pDRAM_SIZE == 16)) begin : g_bad_size
      $error("asu_ddr5_crc_generator: pDRAM_SIZE must be 4, 8 or 16");
    end
  endgenerate

  crc_state_t        state;
  crc_state_t        state_next;
  logic [2:0]        cnt;
  logic              take;
  logic              burst_done;
  logic              use_seed;
  logic [7:0]        lane_crc [NUM_LANES];
  logic [CODE_W-1:0] code_next;

  assign take = crc_enable_i && !crc_clear_i;

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      asu_ddr5_crc_lane #(
        .LANE_W (LANE_W)
      ) u_lane (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (crc_clear_i),
        .enable    (take),
        .use_seed  (use_seed),
        .even_beat (crc_data_i[l*8 +: LANE_W]),
        .odd_beat  (crc_data_i[pDRAM_SIZE + l*8 +: LANE_W]),
        .crc_next  (lane_crc[l])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the first enabled cycle opens a burst, the eighth closes it.
  always_comb begin
    state_next = state;
    if (crc_clear_i) begin
      state_next = IDLE;
    end else if (crc_enable_i) begin
      case (state)
        IDLE:    state_next = ACCUM;
        ACCUM:   state_next = (cnt == 3'd7) ? IDLE : ACCUM;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: busy follows the registered state, the seed is selected on
  // the opening cycle, and the eighth enabled cycle completes the burst.
  always_comb begin
    crc_busy_o = (state == ACCUM);
    use_seed   = (state == IDLE);
    burst_done = take && (state == ACCUM) && (cnt == 3'd7);
  end

  // Enabled-cycle counter; wraps from 7 to 0 exactly at burst completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= 3'd0;
    end else if (crc_clear_i) begin
      cnt <= 3'd0;
    end else if (crc_enable_i) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Code word assembly: lane CRCs in the low bytes, unused beats filled with
  // 1s. Injection touches only bit 0 of each lane CRC, never the filler.
  always_comb begin
    code_next = '1;
    for (int l = 0; l < NUM_LANES; l++) begin
      code_next[l*8 +: 8] = lane_crc[l];
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
      code_next[l*8] = lane_crc[l][0] ^ crc_inject_i;
`endif
    end
  end

  // Output register: the code word holds until the next burst completes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      crc_code_o  <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      crc_valid_o <= burst_done;
      if (burst_done) begin
        crc_code_o <= code_next;
      end
    end
  end

endmodule

// File: tb/tb_asu_ddr5_crc_generator.sv
// ---------------------------------------------------------------------------
// tb_asu_ddr5_crc_generator
// Drives x4, x8 and x16 instances of the CRC generator with directed bursts.
// Expected code words and their completion cycles are queued as each burst
// is issued; per-instance monitors pop and compare whenever crc_valid_o is
// seen. Build option: ASU_DDR5_CRC_ERR_INJ_EN adds the injection bursts.
// ---------------------------------------------------------------------------
module tb_asu_ddr5_crc_generator;

  typedef struct {
    logic [31:0] code;
    int          cyc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;

  logic        en4 = 1'b0, clr4 = 1'b0;
  logic [7:0]  d4 = '0;
  logic [7:0]  code4;
  logic        valid4, busy4;
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
  logic        inj4 = 1'b0;
`endif

  logic        en8 = 1'b0, clr8 = 1'b0;
  logic [15:0] d8 = '0;
  logic [15:0] code8;
  logic        valid8, busy8;

  logic        en16 = 1'b0, clr16 = 1'b0;
  logic [31:0] d16 = '0;
  logic [31:0] code16;
  logic        valid16, busy16;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  asu_ddr5_crc_generator #(.pDRAM_SIZE(4)) u_x4 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .crc_enable_i (en4),
    .crc_data_i   (d4),
    .crc_clear_i  (clr4),
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
    .crc_inject_i (inj4),
`endif
    .crc_code_o   (code4),
    .crc_valid_o  (valid4),
    .crc_busy_o   (busy4)
  );

  asu_ddr5_crc_generator #(.pDRAM_SIZE(8)) u_x8 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .crc_enable_i (en8),
    .crc_data_i   (d8),
    .crc_clear_i  (clr8),
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
    .crc_inject_i (1'b0),
`endif
    .crc_code_o   (code8),
    .crc_valid_o  (valid8),
    .crc_busy_o   (busy8)
  );

  asu_ddr5_crc_generator #(.pDRAM_SIZE(16)) u_x16 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .crc_enable_i (en16),
    .crc_data_i   (d16),
    .crc_clear_i  (clr16),
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
    .crc_inject_i (1'b0),
`endif
    .crc_code_o   (code16),
    .crc_valid_o  (valid16),
    .crc_busy_o   (busy16)
  );

  // Direct comparison of a sampled value against its expected value.
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compares one observed valid pulse against the head of its queue.
  task automatic checkValid(input string nm, input logic [31:0] act, input exp_t e, input bit have);
    total++;
    if (!have) begin
      bad++;
      $display("[TB] FAIL %s unexpected valid: got code %h at cycle %0d, none expected", nm, act, cyc);
    end else if (act !== e.code || cyc != e.cyc) begin
      bad++;
      $display("[TB] FAIL %s code: got %h at cycle %0d expected %h at cycle %0d",
               nm, act, cyc, e.code, e.cyc);
    end
  endtask

  // One cycle of stimulus for the selected instance; the others idle.
  task automatic applyStimulus(input int dut, input logic [31:0] data, input bit en, input bit clr);
    @(posedge clk_i);
    #1;
    en4 = 1'b0; clr4 = 1'b0; d4 = '0;
    en8 = 1'b0; clr8 = 1'b0; d8 = '0;
    en16 = 1'b0; clr16 = 1'b0; d16 = '0;
`ifdef ASU_DDR5_CRC_ERR_INJ_EN
    inj4 = 1'b0;
`endif
    case (dut)
      4:       begin en4 = en;  clr4 = clr;  d4 = data[7:0];   end
      8:       begin en8 = en;  clr8 = clr;  d8 = data[15:0];  end
      default: begin en16 = en; clr16 = clr; d16 = data;       end
    endcase
  endtask

  // The completing cycle is sampled at the next edge, so the pulse is seen
  // on the falling edge after it.
  task automatic pushExpected(input int dut, input logic [31:0] code);
    exp_t e;
    e.code = code;
    e.cyc  = cyc + 1;
    case (dut)
      4:       q4.push_back(e);
      8:       q8.push_back(e);
      default: q16.push_back(e);
    endcase
  endtask

  // Eight enabled cycles, all zero except the last; optional idle gap.
  task automatic sendBurst(input int dut, input logic [31:0] last_data, input int gap_after,
                           input int gaps, input logic [31:0] exp_code);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        applyStimulus(dut, last_data, 1'b1, 1'b0);
        pushExpected(dut, exp_code);
      end else begin
        applyStimulus(dut, 32'h0, 1'b1, 1'b0);
      end
      if (i == gap_after) begin
        repeat (gaps) applyStimulus(dut, 32'h0, 1'b0, 1'b0);
      end
    end
  endtask

  always @(negedge clk_i) begin : mon4
    exp_t e;
    bit   have;
    if (valid4) begin
      e = '{code: 32'h0, cyc: 0};
      have = (q4.size() > 0);
      if (have) e = q4.pop_front();
      checkValid("x4", {24'h0, code4}, e, have);
    end
  end

  always @(negedge clk_i) begin : mon8
    exp_t e;
    bit   have;
    if (valid8) begin
      e = '{code: 32'h0, cyc: 0};
      have = (q8.size() > 0);
      if (have) e = q8.pop_front();
      checkValid("x8", {16'h0, code8}, e, have);
    end
  end

  always @(negedge clk_i) begin : mon16
    exp_t e;
    bit   have;
    if (valid16) begin
      e = '{code: 32'h0, cyc: 0};
      have = (q16.size() > 0);
      if (have) e = q16.pop_front();
      checkValid("x16", code16, e, have);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset code4", {24'h0, code4}, 32'h0);
    checkOutput("reset valid4", {31'h0, valid4}, 32'h0);
    checkOutput("reset busy4", {31'h0, busy4}, 32'h0);
    checkOutput("reset code8", {16'h0, code8}, 32'h0);
    checkOutput("reset code16", code16, 32'h0);
    checkOutput("reset busy16", {31'h0, busy16}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // x4 bursts: all zero, last bit, next-to-last bit, beat 14 DQ3
    sendBurst(4, 32'h00, 0, 0, 32'h00);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);
    checkOutput("busy4 after burst", {31'h0, busy4}, 32'h0);
    sendBurst(4, 32'h80, 0, 0, 32'h07);
    sendBurst(4, 32'h40, 0, 0, 32'h0E);
    sendBurst(4, 32'h08, 0, 0, 32'h70);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);

    // x8: last bit, same with three idle gaps, last two bits
    sendBurst(8, 32'h8000, 0, 0, 32'hFF07);
    sendBurst(8, 32'h8000, 4, 3, 32'hFF07);
    sendBurst(8, 32'hC000, 0, 0, 32'hFF09);
    applyStimulus(8, 32'h0, 1'b0, 1'b0);

    // x16: two back-to-back bursts, lane1 then lane0 last bit
    sendBurst(16, 32'h8000_0000, 0, 0, 32'hFFFF_0700);
    sendBurst(16, 32'h0080_0000, 0, 0, 32'hFFFF_0007);
    applyStimulus(16, 32'h0, 1'b0, 1'b0);
    applyStimulus(16, 32'h0, 1'b0, 1'b0);

    // x4 clear after 5 enabled cycles of ones
    for (int i = 0; i < 5; i++) applyStimulus(4, 32'hFF, 1'b1, 1'b0);
    checkOutput("busy4 mid burst", {31'h0, busy4}, 32'h1);
    applyStimulus(4, 32'hFF, 1'b1, 1'b1);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);
    checkOutput("busy4 after clear", {31'h0, busy4}, 32'h0);
    checkOutput("code4 held after clear", {24'h0, code4}, 32'h70);
    sendBurst(4, 32'h80, 0, 0, 32'h07);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);

    // x4 reset asserted mid-burst
    for (int i = 0; i < 3; i++) applyStimulus(4, 32'hFF, 1'b1, 1'b0);
    #3;
    rst_i = 1'b0;
    #1;
    checkOutput("async reset code4", {24'h0, code4}, 32'h0);
    checkOutput("async reset busy4", {31'h0, busy4}, 32'h0);
    checkOutput("async reset code8", {16'h0, code8}, 32'h0);
    en4 = 1'b0;
    d4  = '0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    sendBurst(4, 32'h80, 0, 0, 32'h07);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);

`ifdef ASU_DDR5_CRC_ERR_INJ_EN
    // Injection on the completing cycle only, then a clean burst
    for (int i = 0; i < 7; i++) applyStimulus(4, 32'h0, 1'b1, 1'b0);
    applyStimulus(4, 32'h80, 1'b1, 1'b0);
    inj4 = 1'b1;
    pushExpected(4, 32'h06);
    sendBurst(4, 32'h80, 0, 0, 32'h07);
    applyStimulus(4, 32'h0, 1'b0, 1'b0);
`endif

    repeat (5) applyStimulus(4, 32'h0, 1'b0, 1'b0);
    checkOutput("x4 pending pulses", q4.size(), 32'h0);
    checkOutput("x8 pending pulses", q8.size(), 32'h0);
    checkOutput("x16 pending pulses", q16.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
